// File: rtl/lab3_mem_bank_mem_arbiter_pkg.sv
// rtl/lab3_mem_bank_mem_arbiter_pkg.sv - shared widths and round-robin pick helper for the bank memory arbiter
package lab3_mem_bank_mem_arbiter_pkg;

  // Default 16B memory message widths (request / response)
  localparam int unsigned MEM_REQ_16B_NBITS  = 176;
  localparam int unsigned MEM_RESP_16B_NBITS = 146;

  // Upper bound on banks the pick helper can scan; bank ids fit in PICK_NBITS
  localparam int unsigned MAX_BANKS  = 32;
  localparam int unsigned PICK_NBITS = $clog2(MAX_BANKS);

  // Returns the first set bit of val scanning upward from ptr, wrapping through mask (= banks-1).
  // With no bit set the result is ptr; callers treat it as don't-care in that case.
  function automatic logic [PICK_NBITS-1:0] rr_pick(
    input logic [MAX_BANKS-1:0]  val,
    input logic [PICK_NBITS-1:0] ptr,
    input logic [PICK_NBITS-1:0] mask
  );
    logic                  found;
    logic [PICK_NBITS-1:0] idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_BANKS; k++) begin
      idx = (ptr + PICK_NBITS'(k)) & mask;
      if (!found && val[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/lab3_mem_owner_queue.sv
// rtl/lab3_mem_owner_queue.sv - in-order FIFO of bank ids owning outstanding memory transactions
module lab3_mem_owner_queue #(
  parameter int unsigned p_depth    = 4,
  parameter int unsigned p_id_nbits = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enq_val,
  output logic                  enq_rdy,
  input  logic [p_id_nbits-1:0] enq_id,
  output logic                  deq_val,
  input  logic                  deq_rdy,
  output logic [p_id_nbits-1:0] deq_id,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_NBITS = $clog2(p_depth);
  localparam int unsigned CNT_NBITS = $clog2(p_depth + 1);

  logic [p_id_nbits-1:0] slots [p_depth];
  logic [PTR_NBITS-1:0]  wr_ptr;
  logic [PTR_NBITS-1:0]  rd_ptr;
  logic [CNT_NBITS-1:0]  count;
  logic                  enq_fire;
  logic                  deq_fire;

  // Status and handshakes; a full queue refuses enqueue even when a dequeue fires alongside
  always_comb begin
    full     = (count == CNT_NBITS'(p_depth));
    empty    = (count == '0);
    enq_rdy  = !full;
    deq_val  = !empty;
    enq_fire = enq_val & enq_rdy;
    deq_fire = deq_val & deq_rdy;
    deq_id   = slots[rd_ptr];
  end

  // Id storage, written at the tail on enqueue
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      slots[wr_ptr] <= enq_id;
    end
  end

  // Pointers and occupancy wrap modulo the depth; reset discards every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= (wr_ptr == PTR_NBITS'(p_depth - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (deq_fire) begin
        rd_ptr <= (rd_ptr == PTR_NBITS'(p_depth - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CNT_NBITS'(enq_fire) - CNT_NBITS'(deq_fire);
    end
  end

endmodule

// File: rtl/lab3_mem_bank_mem_arbiter.sv
// rtl/lab3_mem_bank_mem_arbiter.sv - round-robin share of one memory port among cache banks with in-order response steering
module lab3_mem_bank_mem_arbiter
  import lab3_mem_bank_mem_arbiter_pkg::*;
#(
  parameter int unsigned p_num_banks    = 4,
  parameter int unsigned p_req_nbits    = MEM_REQ_16B_NBITS,
  parameter int unsigned p_resp_nbits   = MEM_RESP_16B_NBITS,
  parameter int unsigned p_max_inflight = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [p_num_banks-1:0]              bank_req_val,
  output logic [p_num_banks-1:0]              bank_req_rdy,
  input  logic [p_num_banks*p_req_nbits-1:0]  bank_req_msg,
  output logic [p_num_banks-1:0]              bank_resp_val,
  input  logic [p_num_banks-1:0]              bank_resp_rdy,
  output logic [p_num_banks*p_resp_nbits-1:0] bank_resp_msg,
  output logic                                memreq_val,
  input  logic                                memreq_rdy,
  output logic [p_req_nbits-1:0]              memreq_msg,
  input  logic                                memresp_val,
  output logic                                memresp_rdy,
  input  logic [p_resp_nbits-1:0]             memresp_msg
);

  localparam int unsigned ID_NBITS = $clog2(p_num_banks);

  logic [ID_NBITS-1:0]    rr_ptr;
  logic [ID_NBITS-1:0]    grant_id;
  logic [ID_NBITS-1:0]    head_id;
  logic [p_num_banks-1:0] grant;
  logic                   any_val;
  logic                   q_enq_val;
  logic                   q_enq_rdy;
  logic                   q_deq_val;
  logic                   q_deq_rdy;
  logic                   q_full;
  logic                   q_empty;
  logic                   req_fire;

  // Combinational round-robin grant, request mux and per-bank ready
  always_comb begin
    any_val  = |bank_req_val;
    grant_id = ID_NBITS'(rr_pick(MAX_BANKS'(bank_req_val), PICK_NBITS'(rr_ptr),
                                 PICK_NBITS'(p_num_banks - 1)));
    grant    = '0;
    if (any_val) begin
      grant[grant_id] = 1'b1;
    end
    memreq_val   = !reset & any_val & !q_full;
    memreq_msg   = bank_req_msg[grant_id*p_req_nbits +: p_req_nbits];
    bank_req_rdy = grant & {p_num_banks{!reset & memreq_rdy & q_enq_rdy}};
    req_fire     = memreq_val & memreq_rdy;
    q_enq_val    = req_fire;
  end

  // Response steering to the bank at the owner-queue head; the message is broadcast
  always_comb begin
    for (int i = 0; i < p_num_banks; i++) begin
      bank_resp_val[i] = !reset & memresp_val & !q_empty & (head_id == ID_NBITS'(i));
    end
    memresp_rdy   = !reset & q_deq_val & bank_resp_rdy[head_id];
    q_deq_rdy     = memresp_val & memresp_rdy;
    bank_resp_msg = {p_num_banks{memresp_msg}};
  end

  // Round-robin pointer moves just past the granted bank on each request fire
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (req_fire) begin
      rr_ptr <= grant_id + ID_NBITS'(1);
    end
  end

  lab3_mem_owner_queue #(
    .p_depth    (p_max_inflight),
    .p_id_nbits (ID_NBITS)
  ) u_owner_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (q_enq_val),
    .enq_rdy (q_enq_rdy),
    .enq_id  (grant_id),
    .deq_val (q_deq_val),
    .deq_rdy (q_deq_rdy),
    .deq_id  (head_id),
    .full    (q_full),
    .empty   (q_empty)
  );

endmodule

// File: tb/tb_lab3_mem_bank_mem_arbiter.sv
// tb/tb_lab3_mem_bank_mem_arbiter.sv - directed scoreboard bench for the bank memory arbiter
module tb_lab3_mem_bank_mem_arbiter;

  localparam int N  = 4;
  localparam int RQ = 176;
  localparam int RS = 146;
  localparam int D  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    bank_req_val;
  logic [N-1:0]    bank_req_rdy;
  logic [N*RQ-1:0] bank_req_msg;
  logic [N-1:0]    bank_resp_val;
  logic [N-1:0]    bank_resp_rdy;
  logic [N*RS-1:0] bank_resp_msg;
  logic            memreq_val;
  logic            memreq_rdy;
  logic [RQ-1:0]   memreq_msg;
  logic            memresp_val;
  logic            memresp_rdy;
  logic [RS-1:0]   memresp_msg;

  int n_checks = 0;
  int n_fail   = 0;
  int m_rr     = 0;
  int m_q[$];
  int seq      = 0;

  lab3_mem_bank_mem_arbiter #(
    .p_num_banks    (N),
    .p_req_nbits    (RQ),
    .p_resp_nbits   (RS),
    .p_max_inflight (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bank_req_val  (bank_req_val),
    .bank_req_rdy  (bank_req_rdy),
    .bank_req_msg  (bank_req_msg),
    .bank_resp_val (bank_resp_val),
    .bank_resp_rdy (bank_resp_rdy),
    .bank_resp_msg (bank_resp_msg),
    .memreq_val    (memreq_val),
    .memreq_rdy    (memreq_rdy),
    .memreq_msg    (memreq_msg),
    .memresp_val   (memresp_val),
    .memresp_rdy   (memresp_rdy),
    .memresp_msg   (memresp_msg)
  );

  always #5 clk = ~clk;

  function automatic logic [RQ-1:0] mk_req(int b, int s);
    return {112'h0, 32'(s), 32'(b)};
  endfunction

  task automatic chk(string tag, logic [RQ-1:0] got, logic [RQ-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      if (bank_req_val[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  // Drive fresh messages for this cycle and let combinational outputs settle
  task automatic settle();
    for (int i = 0; i < N; i++) bank_req_msg[i*RQ +: RQ] = mk_req(i, seq);
    memresp_msg = {18'(seq), $urandom, $urandom, $urandom, $urandom};
    #2;
  endtask

  // Scoreboard check of every output for this cycle, then advance one clock
  task automatic tick();
    int           g;
    int           head;
    logic         ev;
    logic         enq;
    logic         deq;
    logic         exp_resp_rdy;
    logic [N-1:0] exp_req_rdy;
    logic [N-1:0] exp_resp_val;
    if (reset) begin
      chk("rst_memreq_val", RQ'(memreq_val), RQ'(0));
      chk("rst_bank_req_rdy", RQ'(bank_req_rdy), RQ'(0));
      chk("rst_memresp_rdy", RQ'(memresp_rdy), RQ'(0));
      chk("rst_bank_resp_val", RQ'(bank_resp_val), RQ'(0));
      @(posedge clk); #1;
      m_q.delete();
      m_rr = 0;
      seq++;
      return;
    end
    g            = model_grant();
    ev           = (g >= 0) && (m_q.size() < D);
    enq          = ev && memreq_rdy;
    exp_req_rdy  = enq ? (4'b0001 << g) : 4'b0000;
    head         = (m_q.size() > 0) ? m_q[0] : -1;
    exp_resp_rdy = (head >= 0) && bank_resp_rdy[head];
    exp_resp_val = (head >= 0 && memresp_val) ? (4'b0001 << head) : 4'b0000;
    deq          = memresp_val && exp_resp_rdy;
    chk("sb_memreq_val", RQ'(memreq_val), RQ'(ev));
    chk("sb_bank_req_rdy", RQ'(bank_req_rdy), RQ'(exp_req_rdy));
    chk("sb_memresp_rdy", RQ'(memresp_rdy), RQ'(exp_resp_rdy));
    chk("sb_bank_resp_val", RQ'(bank_resp_val), RQ'(exp_resp_val));
    if (ev) chk("sb_memreq_msg", memreq_msg, mk_req(g, seq));
    if (head >= 0) chk("sb_bank_resp_msg", RQ'(bank_resp_msg[head*RS +: RS]), RQ'(memresp_msg));
    if (deq) void'(m_q.pop_front());
    if (enq) begin
      m_q.push_back(g);
      m_rr = (g + 1) % N;
    end
    @(posedge clk); #1;
    seq++;
  endtask

  task automatic drain(int n);
    bank_req_val  = '0;
    memresp_val   = 1'b1;
    bank_resp_rdy = '1;
    for (int k = 0; k < n; k++) begin
      settle();
      tick();
    end
    memresp_val = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bank_req_val  = 4'b1111;
    bank_req_msg  = '0;
    bank_resp_rdy = '1;
    memreq_rdy    = 1'b1;
    memresp_val   = 1'b1;
    memresp_msg   = '0;

    // Reset with active inputs: every handshake output held low
    settle(); tick();
    reset        = 1'b0;
    bank_req_val = '0;
    memresp_val  = 1'b0;

    // 1. Single bank 2 request, response steered only to bank 2
    bank_req_val = 4'b0100;
    settle();
    chk("t1_req_rdy", RQ'(bank_req_rdy), RQ'(4'b0100));
    chk("t1_req_msg", memreq_msg, mk_req(2, seq));
    tick();
    bank_req_val = '0;
    memresp_val  = 1'b1;
    settle();
    chk("t1_resp_val", RQ'(bank_resp_val), RQ'(4'b0100));
    tick();
    memresp_val = 1'b0;

    // 2. All banks requesting from rr_ptr=0: strict rotation
    reset = 1'b1; settle(); tick(); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bank_req_val = 4'b1111;
      memresp_val  = 1'b1;
      settle();
      chk("t2_grant", RQ'(bank_req_rdy), RQ'(4'b0001 << (i % 4)));
      tick();
    end
    drain(1);

    // 3. Fill the owner queue; full blocks requests even alongside a dequeue
    for (int c = 0; c < 5; c++) begin
      bank_req_val = 4'b1111;
      memresp_val  = 1'b0;
      settle();
      chk("t3_memreq_val", RQ'(memreq_val), RQ'(c < 4));
      chk("t3_any_req_rdy", RQ'(|bank_req_rdy), RQ'(c < 4));
      tick();
    end
    memresp_val = 1'b1;
    settle();
    chk("t3_full_no_bypass", RQ'(memreq_val), RQ'(0));
    chk("t3_deq_rdy", RQ'(memresp_rdy), RQ'(1));
    tick();
    memresp_val = 1'b0;
    settle();
    chk("t3_after_deq_val", RQ'(memreq_val), RQ'(1));
    tick();
    drain(4);

    // 4. In-order return with bank 3 backpressure
    bank_req_val = 4'b0010; settle(); chk("t4_g1", RQ'(bank_req_rdy), RQ'(4'b0010)); tick();
    bank_req_val = 4'b1000; settle(); chk("t4_g3", RQ'(bank_req_rdy), RQ'(4'b1000)); tick();
    bank_req_val = 4'b0001; settle(); chk("t4_g0", RQ'(bank_req_rdy), RQ'(4'b0001)); tick();
    bank_req_val = '0;
    memresp_val  = 1'b1;
    settle(); chk("t4_r1", RQ'(bank_resp_val), RQ'(4'b0010)); tick();
    for (int c = 0; c < 3; c++) begin
      bank_resp_rdy = 4'b0111;
      settle();
      chk("t4_bp_rdy", RQ'(memresp_rdy), RQ'(0));
      chk("t4_bp_val", RQ'(bank_resp_val), RQ'(4'b1000));
      tick();
    end
    bank_resp_rdy = '1;
    settle(); chk("t4_r3", RQ'(bank_resp_val), RQ'(4'b1000)); chk("t4_r3_rdy", RQ'(memresp_rdy), RQ'(1)); tick();
    settle(); chk("t4_r0", RQ'(bank_resp_val), RQ'(4'b0001)); tick();
    memresp_val = 1'b0;

    // 5. Simultaneous enqueue and dequeue with two entries queued
    bank_req_val = 4'b0100; settle(); tick();
    bank_req_val = 4'b0010; settle(); tick();
    bank_req_val = 4'b1000;
    memresp_val  = 1'b1;
    settle();
    chk("t5_deq_head", RQ'(bank_resp_val), RQ'(4'b0100));
    chk("t5_enq_grant", RQ'(bank_req_rdy), RQ'(4'b1000));
    tick();
    memresp_val = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bank_req_val = 4'b1111;
      settle();
      chk("t5_count2_room", RQ'(memreq_val), RQ'(c < 2));
      tick();
    end
    bank_req_val = '0;
    memresp_val  = 1'b1;
    settle();
    chk("t5_second_head", RQ'(bank_resp_val), RQ'(4'b0010));
    tick();
    drain(3);

    // 6. Reset with three outstanding entries
    for (int c = 0; c < 3; c++) begin
      bank_req_val = 4'b1111;
      settle(); tick();
    end
    reset       = 1'b1;
    memresp_val = 1'b1;
    settle(); tick();
    reset        = 1'b0;
    bank_req_val = '0;
    settle();
    chk("t6_memresp_rdy", RQ'(memresp_rdy), RQ'(0));
    chk("t6_resp_val", RQ'(bank_resp_val), RQ'(0));
    tick();
    memresp_val  = 1'b0;
    bank_req_val = 4'b1111;
    settle();
    chk("t6_first_grant", RQ'(bank_req_rdy), RQ'(4'b0001));
    tick();
    bank_req_val = '0;
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
